// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int MAX_CONSEC_M_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_F,
    ST_BUSY_M,
    ST_DONE_F,
    ST_DONE_M
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data, memory and stall signals around the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_valid_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic [DATA_WIDTH-1:0] dm_rdata_o;
  logic                  dm_valid_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  stall_f_o;
  logic                  stall_m_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_rdata_o, if_valid_o, dm_rdata_o, dm_valid_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_f_o, stall_m_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_rdata_o, if_valid_o, dm_rdata_o, dm_valid_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_f_o, stall_m_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port,
// data first, with a consecutive-grant limit so fetch cannot starve.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_CONSEC_M = MAX_CONSEC_M_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CONSEC_M + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(MAX_CONSEC_M);

  state_t                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  fetch_turn;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Once data has won MAX_CONSEC_M times in a row, a waiting fetch goes next.
  assign fetch_turn = bus.if_req_i && (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = bus.if_req_i ? cnt_q : '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.dm_req_i && !fetch_turn) begin
          state_d     = ST_BUSY_M;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          if (bus.if_req_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + cnt_t'(1);
          end
        end else if (bus.if_req_i) begin
          state_d    = ST_BUSY_F;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr_i;
          cnt_d      = '0;
        end
      end
      ST_BUSY_F: begin
        if (bus.mem_ack_i) begin
          state_d    = ST_DONE_F;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = bus.mem_rdata_i;
        end
      end
      ST_BUSY_M: begin
        if (bus.mem_ack_i) begin
          state_d   = ST_DONE_M;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      ST_DONE_F, ST_DONE_M: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_valid_o  = (state_q == ST_DONE_F);
  assign bus.dm_valid_o  = (state_q == ST_DONE_M);
  assign bus.stall_f_o   = bus.if_req_i & ~bus.if_valid_o;
  assign bus.stall_m_o   = bus.dm_req_i & ~bus.dm_valid_o;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 Parameter MAX_CONSEC_M, default 4, maximum back-to-back data grants while fetch waits.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 if_req_i  input  1  fetch request; held until if_valid_o.
REQ-007 if_addr_i  input  ADDR_WIDTH  fetch address (PCF).
REQ-008 if_rdata_o  output  DATA_WIDTH  fetched instruction, valid with if_valid_o.
REQ-009 if_valid_o  output  1  one-cycle fetch-complete pulse.
REQ-010 dm_req_i / dm_we_i  input  1 / 1  data request; write when dm_we_i=1.
REQ-011 dm_addr_i / dm_wdata_i  input  ADDR_WIDTH / DATA_WIDTH  data address (ALUResultM) and store data (WriteDataM).
REQ-012 dm_rdata_o / dm_valid_o  output  DATA_WIDTH / 1  load data and one-cycle complete pulse.
REQ-013 mem_req_o / mem_we_o  output  1 / 1  unified memory request and write strobe.
REQ-014 mem_addr_o / mem_wdata_o  output  ADDR_WIDTH / DATA_WIDTH  memory address and write data.
REQ-015 mem_ack_i / mem_rdata_i  input  1 / DATA_WIDTH  memory acknowledge; read data valid in ack cycle.
REQ-016 stall_f_o / stall_m_o  output  1 / 1  pipeline stall for fetch / memory stage.

Function
REQ-017 FSM states: IDLE, BUSY_F, BUSY_M, DONE_F, DONE_M.
REQ-018 IDLE: dm_req_i granted -> BUSY_M, else if_req_i -> BUSY_F, else stay; exception: if_req_i and consecutive-data-grant count = MAX_CONSEC_M -> BUSY_F.
REQ-019 Consecutive count increments on each data grant while if_req_i=1, clears on any fetch grant or when if_req_i=0, saturates at MAX_CONSEC_M.
REQ-020 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o are registered: asserted first cycle in BUSY_x, held stable until mem_ack_i sampled high.
REQ-021 Fetch grant drives mem_we_o=0; data grant drives mem_we_o=dm_we_i captured at grant.
REQ-022 BUSY_x with mem_ack_i=1 -> DONE_x; mem_req_o low next cycle; read data captured into x_rdata_o register (writes leave dm_rdata_o unchanged).
REQ-023 DONE_x: x_valid_o=1 for exactly that cycle, no new grant issued -> IDLE.
REQ-024 Minimum latency: request in cycle N, mem_req_o at N+1, ack at N+1, valid at N+2.
REQ-025 stall_f_o = if_req_i & ~if_valid_o; stall_m_o = dm_req_i & ~dm_valid_o (combinational).
REQ-026 Only one memory transaction outstanding; requests arriving while busy wait without loss.
REQ-027 mem_ack_i ignored in IDLE and DONE_x.

Reset
REQ-028 rst_i asserted: FSM -> IDLE, count -> 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_valid_o=0, dm_valid_o=0, if_rdata_o=0, dm_rdata_o=0, immediately and asynchronously.
REQ-029 Reset mid-transaction abandons it; no valid pulse is produced for it.

Structure
REQ-030 Package mem_arb_pkg holds the state enum and default MAX_CONSEC_M.
REQ-031 Single module; no sub-module.

Verification
REQ-032 if_req_i=1 addr 0x10, ack one cycle after mem_req_o, rdata 0x00500093 -> if_valid_o pulse with if_rdata_o=0x00500093, mem_we_o=0.
REQ-033 if_req_i and dm_req_i same cycle (load 0x104) -> data served first, fetch after dm_valid_o; stall_f_o high throughout.
REQ-034 Store dm_we_i=1 addr 0x200 data 0xDEADBEEF, ack delayed 5 cycles -> mem signals stable 5 cycles, dm_valid_o one pulse, dm_rdata_o unchanged.
REQ-035 Continuous dm_req_i with if_req_i held -> fetch granted after 4 data grants.
REQ-036 rst_i pulsed while BUSY_M -> all outputs 0 at once, no dm_valid_o, next request served normally.
REQ-037 Requester holds req through DONE_x -> exactly one memory transaction issued.
